signed_nibble_display: RTL and testbench

- Downstream consumer of the 4-bit two's-complement negation stage.
- Captures a signed 4-bit result on a load strobe and holds it.
- Shows the held value as sign plus decimal magnitude on a two-digit, time-multiplexed, active-low seven-segment display, and drives a sign LED.
- Sits between the lab's arithmetic datapath and the board display pins.

---
 rtl/disp_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 42 ++++
 rtl/signed_nibble_display.sv | 93 +++++++++
 tb/tb_signed_nibble_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// ============================================================================
// Module  : disp_pkg
// Brief   : Seven-segment glyph/anode constants and scan state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_MAG    = 4'b1110;
    localparam logic [3:0] AN_SIGN   = 4'b1101;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        SCAN_MAG  = 1'b0,
        SCAN_SIGN = 1'b1
    } scan_state_t;

    // Invert-plus-one negation for negative values; -8 wraps to unsigned 8.
    function automatic logic [3:0] mag4(input logic [3:0] v);
        return v[3] ? (~v + 4'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module  : seg7_decode
// Brief   : Combinational 4-bit to active-low seven-segment glyph decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_blank,
    input  logic       i_minus,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else if (i_minus) begin
            o_seg = SEG_MINUS;
        end else begin
            case (i_value)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                // Magnitude never exceeds 8; anything larger is shown blank.
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/signed_nibble_display.sv
// ============================================================================
// Module  : signed_nibble_display
// Brief   : Holds a signed nibble and scans it as sign + magnitude on a
//           two-digit active-low seven-segment display.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_nibble_display
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       neg
);

    localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [3:0]       val_q, val_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_state_t      ptr_q, ptr_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q,  an_d;

    logic [3:0]       w_mag;
    logic             w_tick;
    logic             w_is_sign;
    logic [6:0]       w_glyph;

    assign w_mag     = mag4(val_q);
    assign w_tick    = (cnt_q == CNT_MAX);
    assign w_is_sign = (ptr_q == SCAN_SIGN);

    seg7_decode u_decode (
        .i_value (w_mag),
        .i_blank (w_is_sign & ~val_q[3]),
        .i_minus (w_is_sign &  val_q[3]),
        .o_seg   (w_glyph)
    );

    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q + CNT_W'(1);
        ptr_d = ptr_q;
        if (load) begin
            val_d = din;
        end
        if (w_tick) begin
            cnt_d = '0;
        end
        case (ptr_q)
            SCAN_MAG:  if (w_tick) ptr_d = SCAN_SIGN;
            SCAN_SIGN: if (w_tick) ptr_d = SCAN_MAG;
            default:   ptr_d = SCAN_MAG;
        endcase
    end

    // Anode and glyph are both derived from the same (ptr_q, val_q) pair.
    always_comb begin
        an_d  = w_is_sign ? AN_SIGN : AN_MAG;
        seg_d = w_glyph;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= 4'd0;
            cnt_q <= '0;
            ptr_q <= SCAN_MAG;
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign neg = val_q[3];

endmodule

`default_nettype wire

// File: tb/tb_signed_nibble_display.sv
// ============================================================================
// Module  : tb_signed_nibble_display
// Brief   : Directed, table-driven self-checking bench for the display block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signed_nibble_display;

    localparam int CLK_DIV = 4;

    localparam logic [3:0] E_AN_MAG  = 4'b1110;
    localparam logic [3:0] E_AN_SIGN = 4'b1101;
    localparam logic [3:0] E_AN_OFF  = 4'b1111;
    localparam logic [6:0] E_MINUS   = 7'b0111111;
    localparam logic [6:0] E_BLANK   = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       load;
    logic [6:0] seg;
    logic [3:0] an;
    logic       neg;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] din;
        logic       exp_neg;
        logic [6:0] exp_mag_seg;
        logic [6:0] exp_sign_seg;
    } vec_t;

    vec_t vecs[10];

    signed_nibble_display #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .load  (load),
        .seg   (seg),
        .an    (an),
        .neg   (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (an == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Short reset pulse placed between edges; next edge is "edge 1".
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        din     = 4'd0;

        vecs[0] = '{4'b1101, 1'b1, 7'b0110000, E_MINUS};  // -3
        vecs[1] = '{4'b0101, 1'b0, 7'b0010010, E_BLANK};  // +5
        vecs[2] = '{4'b1000, 1'b1, 7'b0000000, E_MINUS};  // -8
        vecs[3] = '{4'b0111, 1'b0, 7'b1111000, E_BLANK};  // +7
        vecs[4] = '{4'b0000, 1'b0, 7'b1000000, E_BLANK};  //  0
        vecs[5] = '{4'b1111, 1'b1, 7'b1111001, E_MINUS};  // -1
        vecs[6] = '{4'b0001, 1'b0, 7'b1111001, E_BLANK};  // +1
        vecs[7] = '{4'b1010, 1'b1, 7'b0000010, E_MINUS};  // -6
        vecs[8] = '{4'b0010, 1'b0, 7'b0100100, E_BLANK};  // +2
        vecs[9] = '{4'b1100, 1'b1, 7'b0011001, E_MINUS};  // -4

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1;
        check("reset_an",  {28'd0, an},  {28'd0, E_AN_OFF});
        check("reset_seg", {25'd0, seg}, {25'd0, E_BLANK});
        check("reset_neg", {31'd0, neg}, 32'd0);
        rst_n = 1'b1;
        step();
        check("first_an",  {28'd0, an},  {28'd0, E_AN_MAG});
        check("first_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        check("first_neg", {31'd0, neg}, 32'd0);

        // Table of loaded values: sign LED, magnitude digit, sign digit
        foreach (vecs[k]) begin
            din  = vecs[k].din;
            load = 1'b1;
            step();
            load = 1'b0;
            check($sformatf("v%0d_neg", k), {31'd0, neg}, {31'd0, vecs[k].exp_neg});
            wait_an(E_AN_MAG, ok);
            check($sformatf("v%0d_mag_found", k), {31'd0, ok}, 32'd1);
            check($sformatf("v%0d_mag_seg", k), {25'd0, seg}, {25'd0, vecs[k].exp_mag_seg});
            wait_an(E_AN_SIGN, ok);
            check($sformatf("v%0d_sign_found", k), {31'd0, ok}, 32'd1);
            check($sformatf("v%0d_sign_seg", k), {25'd0, seg}, {25'd0, vecs[k].exp_sign_seg});
        end

        // Load held high recaptures every cycle
        load = 1'b1;
        din  = 4'b0101;
        step();
        check("hold_neg0", {31'd0, neg}, 32'd0);
        din = 4'b1110;
        step();
        check("hold_neg1", {31'd0, neg}, 32'd1);
        din = 4'b0011;
        step();
        check("hold_neg2", {31'd0, neg}, 32'd0);
        load = 1'b0;

        // Scan period: 4 cycles MAG, 4 cycles SIGN, repeating
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step();
            check($sformatf("scan_an_e%0d", e), {28'd0, an},
                  {28'd0, ((((e - 1) / CLK_DIV) % 2) == 1) ? E_AN_SIGN : E_AN_MAG});
            check($sformatf("scan_an_hi_e%0d", e), {30'd0, an[3:2]}, 32'd3);
        end

        // Load coinciding with the tick cycle
        do_reset();
        repeat (3) step();
        din  = 4'b1111;
        load = 1'b1;
        step();
        load = 1'b0;
        check("sim_neg",      {31'd0, neg}, 32'd1);
        check("sim_old_seg",  {25'd0, seg}, {25'd0, 7'b1000000});
        step();
        check("sim_sign_an",  {28'd0, an},  {28'd0, E_AN_SIGN});
        check("sim_sign_seg", {25'd0, seg}, {25'd0, E_MINUS});

        // Asynchronous reset mid-scan
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_an",  {28'd0, an},  {28'd0, E_AN_OFF});
        check("midrst_seg", {25'd0, seg}, {25'd0, E_BLANK});
        check("midrst_neg", {31'd0, neg}, 32'd0);
        rst_n = 1'b1;
        step();
        check("recover_an",  {28'd0, an},  {28'd0, E_AN_MAG});
        check("recover_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        check("recover_neg", {31'd0, neg}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
